// File: rtl/pong_pkg.sv
// Shared types and default geometry for the pong game controller and the
// drawing logic that reads its position outputs.
package pong_pkg;

  // Game FSM; encoding is visible on state_o
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_OVER  = 3'd4
  } game_state_t;

  // Per-frame update sequencer; the register holds the step whose result
  // is currently visible on the outputs
  typedef enum logic [1:0] {
    U_IDLE    = 2'd0,
    U_PADDLE  = 2'd1,
    U_COLLIDE = 2'd2,
    U_MOVE    = 2'd3
  } upd_step_t;

  localparam logic DIR_DEC = 1'b0;
  localparam logic DIR_INC = 1'b1;

  localparam int DEF_SCREEN_WIDTH  = 640;
  localparam int DEF_SCREEN_HEIGHT = 480;
  localparam int DEF_BALL_WIDTH    = 20;
  localparam int DEF_BALL_HEIGHT   = 27;
  localparam int DEF_PADDLE_POS    = 40;
  localparam int DEF_PADDLE_WIDTH  = 8;
  localparam int DEF_PADDLE_HEIGHT = 30;

  // Step a coordinate by 'step' toward 'inc', saturating at 0 and clamping
  // at 'lim'; the 11-bit sum keeps the clamp compare free of wrap-around.
  function automatic logic [9:0] step_sat(input logic [9:0] val,
                                          input logic       inc,
                                          input logic [9:0] step,
                                          input logic [9:0] lim);
    logic [10:0] sum;
    logic [9:0]  res;
    sum = {1'b0, val} + {1'b0, step};
    if (inc) begin
      res = (sum > {1'b0, lim}) ? lim : sum[9:0];
    end else begin
      res = (val < step) ? 10'd0 : (val - step);
    end
    return res;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// N-bit two-flop synchronizer for asynchronous push buttons.
module btn_sync #(
  parameter int N = 3
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [N-1:0] async_i,
  output logic [N-1:0] sync_o
);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      logic meta_reg;
      logic sync_reg;

      // Two register stages per button to settle metastability
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= async_i[gi];
          sync_reg <= meta_reg;
        end
      end

      assign sync_o[gi] = sync_reg;
    end
  endgenerate

endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-synchronous pong game controller: paddle, collision and ball move
// run as a three-cycle sequence started by frame_tick_i.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int BALL_WIDTH    = DEF_BALL_WIDTH,
  parameter int BALL_HEIGHT   = DEF_BALL_HEIGHT,
  parameter int PADDLE_POS    = DEF_PADDLE_POS,
  parameter int PADDLE_WIDTH  = DEF_PADDLE_WIDTH,
  parameter int PADDLE_HEIGHT = DEF_PADDLE_HEIGHT,
  parameter int BALL_STEP     = 1,
  parameter int PADDLE_STEP   = 2,
  parameter int SERVE_FRAMES  = 60,
  parameter int LIVES         = 3
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       frame_tick_i,
  input  logic       btn_left_i,
  input  logic       btn_right_i,
  input  logic       serve_i,
  output logic [9:0] x_ball_o,
  output logic [9:0] y_ball_o,
  output logic [9:0] y_paddle_o,
  output logic [7:0] score_o,
  output logic [1:0] lives_o,
  output logic [2:0] state_o,
  output logic       busy_o
);

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

  localparam logic [9:0]       X_MAX      = 10'(SCREEN_WIDTH - BALL_WIDTH);
  localparam logic [9:0]       Y_MAX      = 10'(SCREEN_HEIGHT - BALL_HEIGHT);
  localparam logic [9:0]       PAD_MAX    = 10'(SCREEN_HEIGHT - PADDLE_HEIGHT);
  localparam logic [9:0]       X_CENTER   = 10'(SCREEN_WIDTH / 2);
  localparam logic [9:0]       Y_CENTER   = 10'((SCREEN_HEIGHT - BALL_HEIGHT) / 2);
  localparam logic [9:0]       PAD_CENTER = 10'((SCREEN_HEIGHT - PADDLE_HEIGHT) / 2);
  localparam logic [9:0]       B_STEP     = 10'(BALL_STEP);
  localparam logic [9:0]       P_STEP     = 10'(PADDLE_STEP);
  localparam logic [10:0]      PAD_EDGE   = 11'(PADDLE_POS + PADDLE_WIDTH);
  localparam logic [10:0]      B_STEP_W   = 11'(BALL_STEP);
  localparam logic [10:0]      BH_W       = 11'(BALL_HEIGHT);
  localparam logic [10:0]      PH_W       = 11'(PADDLE_HEIGHT);
  localparam logic [CNT_W-1:0] SERVE_CNT  = CNT_W'(SERVE_FRAMES);
  localparam logic [1:0]       LIVES_INIT = 2'(LIVES);

  logic [2:0] btn_s;     // {serve, right, left}, synchronized

  game_state_t      state_reg,    state_next;
  upd_step_t        step_reg,     step_next;
  logic [9:0]       x_ball_reg,   x_ball_next;
  logic [9:0]       y_ball_reg,   y_ball_next;
  logic [9:0]       y_paddle_reg, y_paddle_next;
  logic [7:0]       score_reg,    score_next;
  logic [1:0]       lives_reg,    lives_next;
  logic             x_dir_reg,    x_dir_next;
  logic             y_dir_reg,    y_dir_next;
  logic [CNT_W-1:0] cnt_reg,      cnt_next;
  logic             busy_reg;

  logic [10:0] x_w, y_w, yp_w;
  logic        hit, miss;
  logic [9:0]  paddle_moved;

  btn_sync #(.N(3)) u_btn_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .async_i ({serve_i, btn_right_i, btn_left_i}),
    .sync_o  (btn_s)
  );

  assign x_w  = {1'b0, x_ball_reg};
  assign y_w  = {1'b0, y_ball_reg};
  assign yp_w = {1'b0, y_paddle_reg};

  // Ball crosses the paddle face this step while overlapping it vertically
  assign hit  = (x_dir_reg == DIR_DEC) && (x_w <= PAD_EDGE) &&
                ((x_w + B_STEP_W) > PAD_EDGE) &&
                ((y_w + BH_W) > yp_w) && (y_w < (yp_w + PH_W));
  assign miss = (x_ball_reg == 10'd0) && (x_dir_reg == DIR_DEC) && !hit;

  // Exactly one button moves the paddle; both or neither hold it
  assign paddle_moved = (btn_s[0] ^ btn_s[1]) ?
                        step_sat(y_paddle_reg, btn_s[1], P_STEP, PAD_MAX) :
                        y_paddle_reg;

  // State register for game FSM, sequencer and game datapath
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg    <= ST_IDLE;
      step_reg     <= U_IDLE;
      x_ball_reg   <= X_CENTER;
      y_ball_reg   <= Y_CENTER;
      y_paddle_reg <= PAD_CENTER;
      score_reg    <= 8'd0;
      lives_reg    <= LIVES_INIT;
      x_dir_reg    <= DIR_INC;
      y_dir_reg    <= DIR_INC;
      cnt_reg      <= '0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      step_reg     <= step_next;
      x_ball_reg   <= x_ball_next;
      y_ball_reg   <= y_ball_next;
      y_paddle_reg <= y_paddle_next;
      score_reg    <= score_next;
      lives_reg    <= lives_next;
      x_dir_reg    <= x_dir_next;
      y_dir_reg    <= y_dir_next;
      cnt_reg      <= cnt_next;
      busy_reg     <= (step_next != U_IDLE);
    end
  end

  // Next-state logic: frame tick dispatch, then paddle/collide/move steps
  always_comb begin
    state_next    = state_reg;
    step_next     = step_reg;
    x_ball_next   = x_ball_reg;
    y_ball_next   = y_ball_reg;
    y_paddle_next = y_paddle_reg;
    score_next    = score_reg;
    lives_next    = lives_reg;
    x_dir_next    = x_dir_reg;
    y_dir_next    = y_dir_reg;
    cnt_next      = cnt_reg;

    case (step_reg)
      U_IDLE: begin
        // A tick arriving while a sequence runs never reaches this branch
        if (frame_tick_i) begin
          case (state_reg)
            ST_IDLE: begin
              if (btn_s[2]) begin
                state_next = ST_SERVE;
                cnt_next   = SERVE_CNT;
              end
            end
            ST_OVER: begin
              if (btn_s[2]) begin
                state_next  = ST_SERVE;
                cnt_next    = SERVE_CNT;
                score_next  = 8'd0;
                lives_next  = LIVES_INIT;
                x_ball_next = X_CENTER;
                y_ball_next = Y_CENTER;
              end
            end
            ST_SERVE, ST_MISS, ST_PLAY: begin
              y_paddle_next = paddle_moved;
              step_next     = U_PADDLE;
            end
            default: state_next = ST_IDLE;
          endcase
        end
      end

      U_PADDLE: begin
        if (state_reg == ST_PLAY) begin
          step_next = U_COLLIDE;
          if (hit) begin
            x_dir_next = DIR_INC;
            score_next = (score_reg == 8'hFF) ? score_reg : score_reg + 8'd1;
          end
          if (x_ball_reg >= X_MAX) begin
            x_dir_next = DIR_DEC;
          end
          if (y_ball_reg == 10'd0) begin
            y_dir_next = DIR_INC;
          end else if (y_ball_reg >= Y_MAX) begin
            y_dir_next = DIR_DEC;
          end
          if (miss) begin
            x_dir_next = DIR_INC;
            cnt_next   = SERVE_CNT;
            lives_next = (lives_reg == 2'd0) ? 2'd0 : lives_reg - 2'd1;
            state_next = (lives_reg <= 2'd1) ? ST_OVER : ST_MISS;
          end
        end else begin
          // Serve/miss countdown: one decrement per frame, play resumes at 0
          step_next = U_IDLE;
          if (cnt_reg <= CNT_W'(1)) begin
            cnt_next   = '0;
            state_next = ST_PLAY;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
      end

      U_COLLIDE: begin
        step_next = U_MOVE;
        if (state_reg == ST_PLAY) begin
          x_ball_next = step_sat(x_ball_reg, x_dir_reg, B_STEP, X_MAX);
          y_ball_next = step_sat(y_ball_reg, y_dir_reg, B_STEP, Y_MAX);
        end else if (state_reg == ST_MISS) begin
          // Miss replaces the move with a re-center; game over leaves the ball
          x_ball_next = X_CENTER;
          y_ball_next = Y_CENTER;
        end
      end

      default: step_next = U_IDLE;
    endcase
  end

  assign x_ball_o   = x_ball_reg;
  assign y_ball_o   = y_ball_reg;
  assign y_paddle_o = y_paddle_reg;
  assign score_o    = score_reg;
  assign lives_o    = lives_reg;
  assign state_o    = state_reg;
  assign busy_o     = busy_reg;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: a table of frame-level phases
// walked through a full game, plus cycle-level sequences for tick timing,
// tick dropping and mid-sequence reset.
module tb_pong_game_ctrl;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       frame_tick_i = 1'b0;
  logic       btn_left_i = 1'b0;
  logic       btn_right_i = 1'b0;
  logic       serve_i = 1'b0;
  logic [9:0] x_ball_o;
  logic [9:0] y_ball_o;
  logic [9:0] y_paddle_o;
  logic [7:0] score_o;
  logic [1:0] lives_o;
  logic [2:0] state_o;
  logic       busy_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  pong_game_ctrl dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .frame_tick_i (frame_tick_i),
    .btn_left_i   (btn_left_i),
    .btn_right_i  (btn_right_i),
    .serve_i      (serve_i),
    .x_ball_o     (x_ball_o),
    .y_ball_o     (y_ball_o),
    .y_paddle_o   (y_paddle_o),
    .score_o      (score_o),
    .lives_o      (lives_o),
    .state_o      (state_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int bl;
    int br;
    int sv;
    int ticks;
    int x;
    int y;
    int yp;
    int sc;
    int lv;
    int st;
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_tick();
    @(negedge clk_i);
    frame_tick_i = 1'b1;
    @(negedge clk_i);
    frame_tick_i = 1'b0;
    repeat (4) @(negedge clk_i);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1'b1;
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            bl br sv ticks    x    y   yp sc lv st
    vecs[0]  = '{0, 0, 0,    0, 320, 226, 225, 0, 3, 0};
    vecs[1]  = '{0, 0, 1,    1, 320, 226, 225, 0, 3, 1};
    vecs[2]  = '{0, 0, 0,   59, 320, 226, 225, 0, 3, 1};
    vecs[3]  = '{0, 0, 0,    1, 320, 226, 225, 0, 3, 2};
    vecs[4]  = '{0, 0, 0,    1, 321, 227, 225, 0, 3, 2};
    vecs[5]  = '{1, 0, 0,  120, 441, 347,   0, 0, 3, 2};
    vecs[6]  = '{1, 1, 0,   10, 451, 357,   0, 0, 3, 2};
    vecs[7]  = '{0, 0, 0,   96, 547, 453,   0, 0, 3, 2};
    vecs[8]  = '{0, 0, 0,    1, 548, 452,   0, 0, 3, 2};
    vecs[9]  = '{0, 0, 0,   72, 620, 380,   0, 0, 3, 2};
    vecs[10] = '{0, 0, 0,    1, 619, 379,   0, 0, 3, 2};
    vecs[11] = '{0, 1, 0,   90, 529, 289, 180, 0, 3, 2};
    vecs[12] = '{0, 0, 0,  289, 240,   0, 180, 0, 3, 2};
    vecs[13] = '{0, 0, 0,    1, 239,   1, 180, 0, 3, 2};
    vecs[14] = '{0, 0, 0,  191,  48, 192, 180, 0, 3, 2};
    vecs[15] = '{0, 0, 0,    1,  49, 193, 180, 1, 3, 2};
    vecs[16] = '{0, 0, 0, 1191,   0, 428, 180, 1, 3, 2};
    vecs[17] = '{0, 0, 0,    1, 320, 226, 180, 1, 2, 3};
    vecs[18] = '{0, 0, 0,   60, 320, 226, 180, 1, 2, 2};
    vecs[19] = '{0, 0, 0,  920,   0, 212, 180, 1, 2, 2};
    vecs[20] = '{0, 0, 0,    1, 320, 226, 180, 1, 1, 3};
    vecs[21] = '{0, 0, 0,   60, 320, 226, 180, 1, 1, 2};
    vecs[22] = '{0, 0, 0,  921,   0, 212, 180, 1, 0, 4};
    vecs[23] = '{1, 0, 0,    5,   0, 212, 180, 1, 0, 4};
    vecs[24] = '{0, 0, 1,    1, 320, 226, 180, 0, 3, 1};

    do_reset();

    // Table phases: hold buttons, let them synchronize, issue ticks, compare
    for (int i = 0; i < 25; i++) begin
      @(negedge clk_i);
      btn_left_i  = (vecs[i].bl != 0);
      btn_right_i = (vecs[i].br != 0);
      serve_i     = (vecs[i].sv != 0);
      repeat (3) @(negedge clk_i);
      for (int t = 0; t < vecs[i].ticks; t++) begin
        do_tick();
      end
      chk($sformatf("v%0d.x_ball", i),   int'(x_ball_o),   vecs[i].x);
      chk($sformatf("v%0d.y_ball", i),   int'(y_ball_o),   vecs[i].y);
      chk($sformatf("v%0d.y_paddle", i), int'(y_paddle_o), vecs[i].yp);
      chk($sformatf("v%0d.score", i),    int'(score_o),    vecs[i].sc);
      chk($sformatf("v%0d.lives", i),    int'(lives_o),    vecs[i].lv);
      chk($sformatf("v%0d.state", i),    int'(state_o),    vecs[i].st);
      chk($sformatf("v%0d.busy", i),     int'(busy_o),     0);
      $display("vec %0d: ticks=%0d x=%0d y=%0d yp=%0d score=%0d lives=%0d state=%0d",
               i, vecs[i].ticks, x_ball_o, y_ball_o, y_paddle_o, score_o, lives_o, state_o);
    end
    serve_i = 1'b0;

    // Fresh game up to PLAY for the cycle-level sequences
    do_reset();
    serve_i = 1'b1;
    repeat (3) @(negedge clk_i);
    do_tick();
    serve_i = 1'b0;
    repeat (3) @(negedge clk_i);
    for (int t = 0; t < 60; t++) do_tick();
    chk("seq.play_state", int'(state_o), 2);

    // Tick latency, with a second tick landing mid-sequence
    btn_right_i = 1'b1;
    repeat (3) @(negedge clk_i);
    @(negedge clk_i);
    frame_tick_i = 1'b1;
    @(negedge clk_i);
    frame_tick_i = 1'b0;
    chk("seq.t1_busy", int'(busy_o), 1);
    chk("seq.t1_paddle", int'(y_paddle_o), 227);
    chk("seq.t1_x_hold", int'(x_ball_o), 320);
    frame_tick_i = 1'b1;
    @(negedge clk_i);
    frame_tick_i = 1'b0;
    chk("seq.t2_busy", int'(busy_o), 1);
    chk("seq.t2_x_hold", int'(x_ball_o), 320);
    @(negedge clk_i);
    chk("seq.t3_x", int'(x_ball_o), 321);
    chk("seq.t3_y", int'(y_ball_o), 227);
    chk("seq.t3_busy", int'(busy_o), 1);
    @(negedge clk_i);
    chk("seq.t4_busy", int'(busy_o), 0);
    btn_right_i = 1'b0;
    repeat (6) @(negedge clk_i);
    chk("seq.drop_x", int'(x_ball_o), 321);
    chk("seq.drop_paddle", int'(y_paddle_o), 227);
    $display("seq timing: x=%0d y=%0d yp=%0d busy=%0d", x_ball_o, y_ball_o, y_paddle_o, busy_o);

    // Reset arriving one cycle into a sequence
    @(negedge clk_i);
    frame_tick_i = 1'b1;
    @(negedge clk_i);
    frame_tick_i = 1'b0;
    reset_i = 1'b1;
    @(negedge clk_i);
    chk("rst.x_ball", int'(x_ball_o), 320);
    chk("rst.y_ball", int'(y_ball_o), 226);
    chk("rst.y_paddle", int'(y_paddle_o), 225);
    chk("rst.score", int'(score_o), 0);
    chk("rst.lives", int'(lives_o), 3);
    chk("rst.state", int'(state_o), 0);
    chk("rst.busy", int'(busy_o), 0);
    reset_i = 1'b0;
    $display("seq reset: x=%0d y=%0d state=%0d busy=%0d", x_ball_o, y_ball_o, state_o, busy_o);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
